id_issue_buffer: RTL

- Parametrised multi-entry decoupling buffer between the decoder and the issue stage; generalises the single-slot ID/issue pipeline register to DEPTH entries.
- Carries an opaque decoded-instruction payload plus a control-flow flag.
- Adds an optional control-flow serialisation mode and an occupancy count.
- Decoded entries enter from the decoder/fetch handshake; the head entry is presented to issue with registered outputs.

---
 rtl/id_issue_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/id_issue_buffer.sv
// rtl/id_issue_buffer.sv - DEPTH-entry decode-to-issue decoupling buffer with optional control-flow serialisation.
// Optional stall counter built when ID_ISSUE_BUFFER_PERF_EN is defined.
module id_issue_buffer #(
    parameter int DEPTH        = 2,
    parameter int DATA_W       = 128,
    parameter int CF_SERIALIZE = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic                       in_ctrl_flow_i,
    output logic                       in_ready_o,
    output logic                       issue_valid_o,
    output logic [DATA_W-1:0]          issue_data_o,
    output logic                       issue_ctrl_flow_o,
    input  logic                       issue_ack_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [31:0]                stall_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_cf;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cf_cnt;
    logic              ack_eff;
    logic              cf_ok;
    logic              push;
    logic              pop;
    logic              cf_inc;
    logic              cf_dec;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign issue_valid_o     = (count != '0);
    assign issue_data_o      = mem_data[rd_ptr];
    assign issue_ctrl_flow_o = issue_valid_o && mem_cf[rd_ptr];
    assign count_o           = count;

    assign ack_eff = issue_ack_i && issue_valid_o;

    always_comb begin
        cf_ok = 1'b1;
        if (CF_SERIALIZE != 0) begin
            cf_ok = (cf_cnt == '0) ||
                    ((cf_cnt == CNT_W'(1)) && ack_eff && issue_ctrl_flow_o);
        end
    end

    assign in_ready_o = !flush_i && ((count < CNT_W'(DEPTH)) || ack_eff) && cf_ok;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = ack_eff;
    assign cf_inc     = push && in_ctrl_flow_i;
    assign cf_dec     = pop && issue_ctrl_flow_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data_i;
            mem_cf[wr_ptr]   <= in_ctrl_flow_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            cf_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({cf_inc, cf_dec})
                2'b10:   cf_cnt <= cf_cnt + CNT_W'(1);
                2'b01:   cf_cnt <= cf_cnt - CNT_W'(1);
                default: cf_cnt <= cf_cnt;
            endcase
        end
    end

`ifdef ID_ISSUE_BUFFER_PERF_EN
    logic [31:0] stall_cnt;

    // Survives flush so the counter reflects whole-run back-pressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (in_valid_i && !in_ready_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
